// File: rtl/dsram_periph_resp.sv
// Data-SRAM responder: word-addressed RAM plus a small peripheral window holding
// the timer, the LED register and the switch input, with a one-cycle registered read path.
module dsram_periph_resp #(
  parameter int unsigned RAM_AW    = 10,
  parameter logic [15:0] PERIPH_HI = 16'hbfaf
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch_in,
  output logic [15:0] led_out,
  output logic [7:0]  hw_int
);

  localparam int unsigned Words = 2 ** RAM_AW;

  localparam logic [15:0] OffTimer  = 16'h8000;
  localparam logic [15:0] OffCmp    = 16'h8004;
  localparam logic [15:0] OffCtrl   = 16'h8008;
  localparam logic [15:0] OffLed    = 16'hf000;
  localparam logic [15:0] OffSwitch = 16'hf004;

  logic [31:0] mem [Words];

  logic [31:0] rdata_q, rdata_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] cmp_q, cmp_d;
  logic        en_q, en_d;
  logic        pend_q, pend_d;
  logic [15:0] led_q, led_d;
  logic [7:0]  sw_meta_q, sw_sync_q;

  logic              is_periph;
  logic [15:0]       offset;
  logic [RAM_AW-1:0] ram_idx;
  logic              periph_wr;
  logic [31:0]       periph_rdata;
  logic              unused_addr;

  assign is_periph   = (data_sram_addr[31:16] == PERIPH_HI);
  assign offset      = data_sram_addr[15:0];
  assign ram_idx     = data_sram_addr[RAM_AW+1:2];
  assign unused_addr = ^data_sram_addr[1:0];

  // Peripheral registers only take full-word writes.
  assign periph_wr = data_sram_en && is_periph && (data_sram_we == 4'hf);

  always_comb begin
    periph_rdata = 32'h0;
    case (offset)
      OffTimer:  periph_rdata = timer_q;
      OffCmp:    periph_rdata = cmp_q;
      OffCtrl:   periph_rdata = {30'h0, pend_q, en_q};
      OffLed:    periph_rdata = {16'h0, led_q};
      OffSwitch: periph_rdata = {24'h0, sw_sync_q};
      default:   periph_rdata = 32'h0;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (data_sram_en) begin
      rdata_d = is_periph ? periph_rdata : mem[ram_idx];
    end
  end

  always_comb begin
    timer_d = en_q ? timer_q + 32'd1 : timer_q;
    cmp_d   = cmp_q;
    en_d    = en_q;
    pend_d  = pend_q;
    led_d   = led_q;

    if (periph_wr) begin
      case (offset)
        OffTimer: timer_d = data_sram_wdata;
        OffCmp:   cmp_d   = data_sram_wdata;
        OffCtrl: begin
          en_d = data_sram_wdata[0];
          if (data_sram_wdata[1]) begin
            pend_d = 1'b0;
          end
        end
        OffLed:   led_d = data_sram_wdata[15:0];
        default: ;
      endcase
    end

    // A compare hit in the same cycle as a W1C clear must still leave PEND set.
    if (en_q && (timer_q == cmp_q)) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q   <= 32'h0;
      timer_q   <= 32'h0;
      cmp_q     <= 32'hffff_ffff;
      en_q      <= 1'b0;
      pend_q    <= 1'b0;
      led_q     <= 16'h0;
      sw_meta_q <= 8'h0;
      sw_sync_q <= 8'h0;
    end else begin
      rdata_q   <= rdata_d;
      timer_q   <= timer_d;
      cmp_q     <= cmp_d;
      en_q      <= en_d;
      pend_q    <= pend_d;
      led_q     <= led_d;
      sw_meta_q <= switch_in;
      sw_sync_q <= sw_meta_q;
    end
  end

  // RAM is not reset, but reset still blocks a write issued in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset && data_sram_en && !is_periph) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_we[i]) begin
          mem[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  assign data_sram_rdata = rdata_q;
  assign led_out         = led_q;
  assign hw_int          = {7'h0, pend_q};

endmodule

// File: tb/tb_dsram_periph_resp.sv
// Directed self-checking bench for dsram_periph_resp.
module tb_dsram_periph_resp;

  logic        clk;
  logic        reset;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [7:0]  switch_in;
  logic [15:0] led_out;
  logic [7:0]  hw_int;

  int checks;
  int failures;

  localparam logic [31:0] ATimer  = 32'hbfaf_8000;
  localparam logic [31:0] ACmp    = 32'hbfaf_8004;
  localparam logic [31:0] ACtrl   = 32'hbfaf_8008;
  localparam logic [31:0] ALed    = 32'hbfaf_f000;
  localparam logic [31:0] ASwitch = 32'hbfaf_f004;
  localparam logic [31:0] AUnmap  = 32'hbfaf_8010;

  dsram_periph_resp dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .switch_in       (switch_in),
    .led_out         (led_out),
    .hw_int          (hw_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
    data_sram_en    = 1'b1;
    data_sram_we    = we;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    @(posedge clk);
    #1;
    data_sram_en = 1'b0;
    data_sram_we = 4'h0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    reset           = 1'b1;
    data_sram_en    = 1'b0;
    data_sram_we    = 4'h0;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;
    switch_in       = 8'h00;

    idle(2);
    check("reset_rdata", data_sram_rdata, 32'h0);
    check("reset_led", {16'h0, led_out}, 32'h0);
    check("reset_hwint", {24'h0, hw_int}, 32'h0);
    reset = 1'b0;

    access(4'h0, ATimer, 32'h0);
    check("reset_timer", data_sram_rdata, 32'h0);
    access(4'h0, ACmp, 32'h0);
    check("reset_cmp", data_sram_rdata, 32'hffff_ffff);
    access(4'h0, ACtrl, 32'h0);
    check("reset_ctrl", data_sram_rdata, 32'h0);

    // Byte-lane RAM write and read-before-write
    access(4'hf, 32'h0000_0010, 32'h1122_3344);
    access(4'b0010, 32'h0000_0010, 32'h0000_aa00);
    check("ram_rbw", data_sram_rdata, 32'h1122_3344);
    access(4'h0, 32'h0000_0010, 32'h0);
    check("ram_lane", data_sram_rdata, 32'h1122_aa44);
    idle(1);
    check("rdata_hold", data_sram_rdata, 32'h1122_aa44);

    // LED: partial write ignored, full write applied
    access(4'b0011, ALed, 32'h0000_1234);
    check("led_partial", {16'h0, led_out}, 32'h0);
    access(4'hf, ALed, 32'h0001_beef);
    check("led_full", {16'h0, led_out}, 32'h0000_beef);
    access(4'h0, ALed, 32'h0);
    check("led_read", data_sram_rdata, 32'h0000_beef);

    // Switch synchroniser: two stages before the value is visible
    switch_in = 8'h5a;
    access(4'h0, ASwitch, 32'h0);
    check("sw_lat0", data_sram_rdata, 32'h0);
    access(4'h0, ASwitch, 32'h0);
    check("sw_lat1", data_sram_rdata, 32'h0);
    access(4'h0, ASwitch, 32'h0);
    check("sw_read", data_sram_rdata, 32'h0000_005a);
    access(4'hf, ASwitch, 32'hffff_ffff);
    access(4'h0, ASwitch, 32'h0);
    check("sw_ro", data_sram_rdata, 32'h0000_005a);
    access(4'h0, AUnmap, 32'h0);
    check("unmapped", data_sram_rdata, 32'h0);

    // Timer compare: TIMER==k after the k-th edge following the EN write
    access(4'hf, ACmp, 32'd5);
    access(4'hf, ACtrl, 32'd1);
    idle(5);
    check("pend_early", {24'h0, hw_int}, 32'h0);
    idle(1);
    check("pend_set", {24'h0, hw_int}, 32'h1);
    idle(3);
    check("pend_hold", {24'h0, hw_int}, 32'h1);
    access(4'hf, ACtrl, 32'd3);
    check("pend_clr", {24'h0, hw_int}, 32'h0);
    access(4'h0, ACtrl, 32'h0);
    check("ctrl_read", data_sram_rdata, 32'h1);

    // Wrap with EN still set; bus write beats increment
    access(4'hf, ATimer, 32'hffff_fffe);
    idle(1);
    access(4'h0, ATimer, 32'h0);
    check("timer_max", data_sram_rdata, 32'hffff_ffff);
    access(4'h0, ATimer, 32'h0);
    check("timer_wrap", data_sram_rdata, 32'h0);
    access(4'hf, ACtrl, 32'h2);

    // Reset overriding a RAM write
    access(4'hf, 32'h0000_0020, 32'hcafe_f00d);
    access(4'h0, 32'h0000_0020, 32'h0);
    check("ram_pre", data_sram_rdata, 32'hcafe_f00d);
    access(4'hf, ACmp, 32'd7);
    access(4'hf, ATimer, 32'd100);
    reset = 1'b1;
    access(4'hf, 32'h0000_0020, 32'hdead_beef);
    check("rst_rdata", data_sram_rdata, 32'h0);
    check("rst_led", {16'h0, led_out}, 32'h0);
    reset = 1'b0;
    access(4'h0, 32'h0000_0020, 32'h0);
    check("rst_ram_kept", data_sram_rdata, 32'hcafe_f00d);
    access(4'h0, 32'h0000_0010, 32'h0);
    check("rst_ram_kept2", data_sram_rdata, 32'h1122_aa44);
    access(4'h0, ATimer, 32'h0);
    check("rst_timer", data_sram_rdata, 32'h0);
    access(4'h0, ACmp, 32'h0);
    check("rst_cmp", data_sram_rdata, 32'hffff_ffff);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
